// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button conditioning, run/pause/lap FSM, count-tick
// prescaler, lap capture and a multiplexed four-digit display scan.
`timescale 1ns/1ps
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 5000000,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_stop,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic [3:0] thousands,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic [3:0] an,
  output logic [3:0] bcd,
  output logic [1:0] state,
  output logic       ovf
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam int unsigned NB = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [NB-1:0]   sync1, sync2, sync3, press;
  logic            clr_d, cap_c, running, all_nine;
  logic [PW-1:0]   presc;
  logic [SW-1:0]   scan;
  logic [1:0]      idx;
  logic [3:0][3:0] live, lap_q, src;

  assign live     = {thousands, hundreds, tens, ones};
  assign all_nine = (live == 16'h9999);
  assign running  = (state_q == S_RUN) || (state_q == S_LAP);
  assign cnt_en   = running && (presc == PW'(TICK_DIV - 1));
  assign state    = state_q;
  assign src      = (state_q == S_LAP) ? lap_q : live;

  // Two-flop synchronizer plus a delay flop for rising-edge detection; bit order {clear, lap, start_stop}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= {btn_clear, btn_lap, btn_start_stop};
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign press = sync2 & ~sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state; clear outranks start_stop, which outranks lap.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    cap_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press[2])      clr_d   = 1'b1;
        else if (press[0]) state_d = S_RUN;
      end
      S_RUN: begin
        if (press[0]) state_d = S_PAUSE;
        else if (press[1]) begin
          state_d = S_LAP;
          cap_c   = 1'b1;
        end
      end
      S_LAP: begin
        if (press[0])      state_d = S_PAUSE;
        else if (press[1]) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (press[2]) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end else if (press[0]) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tick prescaler: free-running while counting, frozen in PAUSE, zeroed in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (state_q == S_IDLE) begin
      presc <= '0;
    end else if (running) begin
      presc <= cnt_en ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_clr <= 1'b0;
      ovf     <= 1'b0;
      lap_q   <= '0;
    end else begin
      cnt_clr <= clr_d;
      if (clr_d)                    ovf <= 1'b0;
      else if (cnt_en && all_nine)  ovf <= 1'b1;
      if (cap_c) lap_q <= live;
    end
  end

  // Display scan runs in every state; an/bcd lag the index and source by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan <= '0;
      idx  <= '0;
      an   <= 4'b1110;
      bcd  <= '0;
    end else begin
      if (scan == SW'(SCAN_DIV - 1)) begin
        scan <= '0;
        idx  <= idx + 2'd1;
      end else begin
        scan <= scan + SW'(1);
      end
      an  <= ~(4'b0001 << idx);
      bcd <= src[idx];
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized scoreboard bench for stopwatch_ctrl: a cycle-stamped event model
// predicts state changes, ticks, clears, overflow and display updates.
`timescale 1ns/1ps
module tb_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int SD = 2;
  localparam int EV_STATE = 0, EV_TICK = 1, EV_CLR = 2, EV_OVF = 3, EV_DISP = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] btn = 3'b000;
  logic [3:0] dig [4];
  logic       cnt_en, cnt_clr, ovf;
  logic [3:0] an, bcd;
  logic [1:0] state;

  stopwatch_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_start_stop (btn[0]),
    .btn_lap        (btn[1]),
    .btn_clear      (btn[2]),
    .ones           (dig[0]),
    .tens           (dig[1]),
    .hundreds       (dig[2]),
    .thousands      (dig[3]),
    .cnt_en         (cnt_en),
    .cnt_clr        (cnt_clr),
    .an             (an),
    .bcd            (bcd),
    .state          (state),
    .ovf            (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_checks = 0;
  int  n_fail = 0;
  ev_t sb_q[$];

  // Reference model: 0 idle, 1 run, 2 pause, 3 lap
  int         m_state, m_phase, nrel, m_disp;
  bit         m_ovf, m_en;
  logic [3:0] m_lap [4];
  int         pend [3];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_ev(input int kind, input int val);
    ev_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d at cycle %0d, required no event", kind, val, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.val != val) begin
        n_fail++;
        $display("FAIL event: got cyc=%0d kind=%0d val=%0d, required cyc=%0d kind=%0d val=%0d",
                 cyc, kind, val, e.cyc, e.kind, e.val);
      end
    end
  endtask

  // Monitor: every observable change on the DUT is matched against the queue.
  bit         mon_en = 1'b0;
  logic [1:0] prev_state = 2'b00;
  logic       prev_ovf = 1'b0;
  logic [7:0] prev_disp = 8'hE0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (state != prev_state)       mon_ev(EV_STATE, int'(state));
      if (cnt_en)                    mon_ev(EV_TICK, 1);
      if (cnt_clr)                   mon_ev(EV_CLR, 1);
      if (ovf != prev_ovf)           mon_ev(EV_OVF, int'(ovf));
      if ({an, bcd} != prev_disp)    mon_ev(EV_DISP, int'({an, bcd}));
      n_checks++;
      if (cnt_en && cnt_clr) begin
        n_fail++;
        $display("FAIL en_clr_exclusive: got cnt_en=1 cnt_clr=1 at cycle %0d, required not both", cyc);
      end
    end
    prev_state = state;
    prev_ovf   = ovf;
    prev_disp  = {an, bcd};
  end

  task automatic model_init();
    m_state = 0; m_phase = 0; nrel = 0; m_disp = 'hE0;
    m_ovf = 0; m_en = 0;
    for (int i = 0; i < 4; i++) m_lap[i] = 4'd0;
    for (int i = 0; i < 3; i++) pend[i] = -1;
  endtask

  // Advance the model across one clock edge; dig/m_state still hold the previous cycle.
  task automatic model_edge();
    int  k, idx, src_d, disp, old;
    bit  p_ss, p_lap, p_clr, clr, en, nov, all9;
    k     = cyc;
    idx   = (nrel / SD) % 4;
    src_d = (m_state == 3) ? int'(m_lap[idx]) : int'(dig[idx]);
    disp  = (((~(1 << idx)) & 15) << 4) | src_d;
    all9  = (dig[0] == 9) && (dig[1] == 9) && (dig[2] == 9) && (dig[3] == 9);
    nrel++;
    p_ss  = (pend[0] == k);
    p_lap = (pend[1] == k);
    p_clr = (pend[2] == k);
    old   = m_state;
    clr   = 0;
    case (m_state)
      0: if (p_clr) clr = 1; else if (p_ss) m_state = 1;
      1: if (p_ss) m_state = 2; else if (p_lap) begin m_state = 3; m_lap = dig; end
      3: if (p_ss) m_state = 2; else if (p_lap) m_state = 1;
      default: if (p_clr) begin m_state = 0; clr = 1; end else if (p_ss) m_state = 1;
    endcase
    nov = m_ovf;
    if (m_en && all9) nov = 1;
    if (clr) nov = 0;
    if (old == 1 || old == 3) m_phase = (m_phase + 1) % TD;
    else if (old == 0)        m_phase = 0;
    en = (m_state == 1 || m_state == 3) && (m_phase == TD - 1);
    if (m_state != old) sb_q.push_back('{k, EV_STATE, m_state});
    if (en)             sb_q.push_back('{k, EV_TICK, 1});
    if (clr)            sb_q.push_back('{k, EV_CLR, 1});
    if (nov != m_ovf)   sb_q.push_back('{k, EV_OVF, int'(nov)});
    if (disp != m_disp) sb_q.push_back('{k, EV_DISP, disp});
    m_ovf  = nov;
    m_en   = en;
    m_disp = disp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    for (int b = 0; b < 3; b++) begin
      if (m[b]) begin
        btn[b]  = 1'b1;
        pend[b] = cyc + 3;
      end
    end
    repeat (hold) tick();
    btn = btn & ~m;
    tick();
  endtask

  task automatic set_dig(input int th, input int hu, input int te, input int on);
    dig[3] = 4'(th); dig[2] = 4'(hu); dig[1] = 4'(te); dig[0] = 4'(on);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    btn    = 3'b000;
    rst_n  = 1'b0;
    #2;
    chk("rst_state",   int'(state),   0);
    chk("rst_cnt_en",  int'(cnt_en),  0);
    chk("rst_cnt_clr", int'(cnt_clr), 0);
    chk("rst_an",      int'(an),      'hE);
    chk("rst_bcd",     int'(bcd),     0);
    chk("rst_ovf",     int'(ovf),     0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_init();
    sb_q.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dig[i] = 4'd0;
    model_init();
    #1;
    do_reset();

    // Start and run for several tick periods
    press(3'b001, 2);
    repeat (12) tick();

    // Pause and resume at each prescaler phase
    for (int d = 0; d < 4; d++) begin
      repeat (d) tick();
      press(3'b001, 2);
      repeat (3) tick();
      press(3'b001, 3);
      repeat (2) tick();
    end

    // Lap freezes the display while live digits move on
    set_dig(1, 2, 4, 0);
    tick();
    press(3'b010, 4);
    set_dig(1, 2, 5, 0);
    repeat (10) tick();
    press(3'b010, 2);
    repeat (8) tick();

    // Clear ignored in RUN, honoured in PAUSE
    press(3'b100, 2);
    repeat (2) tick();
    press(3'b001, 2);
    press(3'b100, 2);
    repeat (3) tick();

    // Overflow at 9999, held through PAUSE, cleared by clear
    press(3'b001, 2);
    set_dig(9, 9, 9, 9);
    repeat (6) tick();
    press(3'b001, 2);
    repeat (4) tick();
    press(3'b100, 2);
    set_dig(0, 0, 0, 0);
    repeat (3) tick();

    // Simultaneous start_stop + lap in RUN; then reset mid-run
    press(3'b001, 2);
    repeat (3) tick();
    press(3'b011, 2);
    repeat (3) tick();
    press(3'b001, 2);
    repeat (2) tick();
    do_reset();
    repeat (8) tick();

    // Randomized mix of presses, digit changes, idle time and resets
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        press(3'($urandom_range(1, 7)), $urandom_range(2, 5));
      end else if (r < 6) begin
        press(3'(1 << $urandom_range(0, 2)), $urandom_range(2, 4));
      end else if (r < 8) begin
        if ($urandom_range(0, 3) == 0) set_dig(9, 9, 9, 9);
        else for (int i = 0; i < 4; i++) dig[i] = 4'($urandom_range(0, 9));
        tick();
      end else if (r == 8) begin
        repeat ($urandom_range(1, 8)) tick();
      end else if ($urandom_range(0, 7) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end

    repeat (4) tick();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
